// File: rtl/yazmac_yaz_hakemi_pkg.sv
// Shared definitions for the register-file write-port arbiter: buffer state
// encodings, grant selector, default starvation threshold and datapath widths.
package yazmac_yaz_hakemi_pkg;

  localparam int ADRES_W               = 5;
  localparam int VERI_W                = 32;
  localparam int ACLIK_ESIK_VARSAYILAN = 8;

  typedef enum logic {
    HAKEM_BOS  = 1'b0,
    HAKEM_DOLU = 1'b1
  } hakem_durum_e;

  typedef enum logic [1:0] {
    IZIN_YOK = 2'd0,
    IZIN_GY  = 2'd1,
    IZIN_UZ  = 2'd2
  } izin_e;

endpackage

// File: rtl/yazmac_yaz_hakemi_puan_tablosu.sv
// Pending-destination scoreboard: one bit per architectural register, set on
// long-latency issue, cleared when the buffered result is written.
module yazmac_puan_tablosu
  import yazmac_yaz_hakemi_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_set_gecerli,
  input  logic [ADRES_W-1:0] i_set_adres,
  input  logic               i_sil_gecerli,
  input  logic [ADRES_W-1:0] i_sil_adres,
  input  logic [ADRES_W-1:0] i_sorgu_rs1,
  input  logic [ADRES_W-1:0] i_sorgu_rs2,
  input  logic [ADRES_W-1:0] i_sorgu_rd,
  output logic               o_bekle
);

  logic [31:0] r_maske;
  logic [31:0] w_set_maske;
  logic [31:0] w_sil_maske;
  logic [31:0] w_maske_sonraki;

  always_comb begin
    w_set_maske = '0;
    w_sil_maske = '0;
    if (i_set_gecerli) w_set_maske[i_set_adres] = 1'b1;
    if (i_sil_gecerli) w_sil_maske[i_sil_adres] = 1'b1;
    // a re-issue to the register being retired keeps it pending
    w_maske_sonraki    = (r_maske & ~w_sil_maske) | w_set_maske;
    w_maske_sonraki[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_maske <= '0;
    else       r_maske <= w_maske_sonraki;
  end

  assign o_bekle = r_maske[i_sorgu_rs1] | r_maske[i_sorgu_rs2] | r_maske[i_sorgu_rd];

endmodule

// File: rtl/yazmac_yaz_hakemi.sv
// Write-port arbiter between the pipeline write-back and a one-entry buffer of
// long-latency results. Starvation stall guarded by YAZ_HAKEM_ACLIK_KORUMA_EN.
module yazmac_yaz_hakemi
  import yazmac_yaz_hakemi_pkg::*;
#(
  parameter int unsigned ACLIK_ESIK = ACLIK_ESIK_VARSAYILAN
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               gy_gecerli_i,
  input  logic [ADRES_W-1:0] gy_adres_i,
  input  logic [VERI_W-1:0]  gy_deger_i,
  input  logic               uz_gecerli_i,
  input  logic [ADRES_W-1:0] uz_adres_i,
  input  logic [VERI_W-1:0]  uz_deger_i,
  output logic               uz_hazir_o,
  input  logic               uz_basla_i,
  input  logic [ADRES_W-1:0] uz_basla_adres_i,
  input  logic [ADRES_W-1:0] sorgu_rs1_i,
  input  logic [ADRES_W-1:0] sorgu_rs2_i,
  input  logic [ADRES_W-1:0] sorgu_rd_i,
  output logic               bekle_o,
  output logic               durdur_o,
  output logic [ADRES_W-1:0] yaz_adres_o,
  output logic [VERI_W-1:0]  yaz_deger_o,
  output logic               yaz_yazmac_o
);

  if (ACLIK_ESIK < 1 || ACLIK_ESIK > 255) begin : g_esik_hatali
    $error("ACLIK_ESIK must be in 1..255");
  end

  hakem_durum_e       r_durum;
  hakem_durum_e       w_durum_sonraki;
  logic [ADRES_W-1:0] r_tampon_adres;
  logic [VERI_W-1:0]  r_tampon_deger;
  logic [ADRES_W-1:0] r_yaz_adres;
  logic [VERI_W-1:0]  r_yaz_deger;
  logic               r_yaz_yazmac;
  izin_e              w_izin;
  logic               w_bosalt;
  logic               w_durdur;

  always_comb begin
    w_izin = IZIN_YOK;
    if (w_durdur && (r_durum == HAKEM_DOLU)) w_izin = IZIN_UZ;
    else if (gy_gecerli_i)                   w_izin = IZIN_GY;
    else if (r_durum == HAKEM_DOLU)          w_izin = IZIN_UZ;
  end

  assign w_bosalt = (w_izin == IZIN_UZ);

  always_comb begin
    w_durum_sonraki = r_durum;
    case (r_durum)
      HAKEM_BOS:  if (uz_gecerli_i) w_durum_sonraki = HAKEM_DOLU;
      HAKEM_DOLU: if (w_bosalt)     w_durum_sonraki = HAKEM_BOS;
      default:                      w_durum_sonraki = HAKEM_BOS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum        <= HAKEM_BOS;
      r_tampon_adres <= '0;
      r_tampon_deger <= '0;
    end else begin
      r_durum <= w_durum_sonraki;
      if ((r_durum == HAKEM_BOS) && uz_gecerli_i) begin
        r_tampon_adres <= uz_adres_i;
        r_tampon_deger <= uz_deger_i;
      end
    end
  end

  // address/data hold on idle cycles; only the enable drops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_yaz_adres  <= '0;
      r_yaz_deger  <= '0;
      r_yaz_yazmac <= 1'b0;
    end else begin
      case (w_izin)
        IZIN_GY: begin
          r_yaz_adres  <= gy_adres_i;
          r_yaz_deger  <= gy_deger_i;
          r_yaz_yazmac <= (gy_adres_i != '0);
        end
        IZIN_UZ: begin
          r_yaz_adres  <= r_tampon_adres;
          r_yaz_deger  <= r_tampon_deger;
          r_yaz_yazmac <= (r_tampon_adres != '0);
        end
        default: r_yaz_yazmac <= 1'b0;
      endcase
    end
  end

`ifdef YAZ_HAKEM_ACLIK_KORUMA_EN
  logic [7:0] r_aclik_sayac;
  logic       r_durdur;
  logic       w_kaybetti;

  assign w_kaybetti = (r_durum == HAKEM_DOLU) && (w_izin == IZIN_GY);

  always_ff @(posedge clk_i) begin
    if (rst_i || w_bosalt) begin
      r_aclik_sayac <= '0;
      r_durdur      <= 1'b0;
    end else if (w_kaybetti) begin
      r_aclik_sayac <= r_aclik_sayac + 8'd1;
      if (r_aclik_sayac == 8'(ACLIK_ESIK - 1)) r_durdur <= 1'b1;
    end
  end

  assign w_durdur = r_durdur;
`else
  assign w_durdur = 1'b0;
`endif

  yazmac_puan_tablosu u_puan_tablosu (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_set_gecerli (uz_basla_i && (uz_basla_adres_i != '0)),
    .i_set_adres   (uz_basla_adres_i),
    .i_sil_gecerli (w_bosalt),
    .i_sil_adres   (r_tampon_adres),
    .i_sorgu_rs1   (sorgu_rs1_i),
    .i_sorgu_rs2   (sorgu_rs2_i),
    .i_sorgu_rd    (sorgu_rd_i),
    .o_bekle       (bekle_o)
  );

  assign uz_hazir_o   = (r_durum == HAKEM_BOS);
  assign durdur_o     = w_durdur;
  assign yaz_adres_o  = r_yaz_adres;
  assign yaz_deger_o  = r_yaz_deger;
  assign yaz_yazmac_o = r_yaz_yazmac;

endmodule
